// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared codes, field widths and state type for the MDIO responder
//
// Purpose: Clause-22 frame constants and FSM state enum used by mdio_responder.
// Ports:   none (package).

package mdio_pkg;

    // Start-of-frame code, sent MSB first: a 0 followed by a 1.
    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int OP_W    = 2;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int TA_W    = 2;
    localparam int DATA_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        ST,
        OP,
        PHYAD,
        REGAD,
        TA,
        DATA
    } state_t;

    // Index of the final bit of a field, in the width of the bit counter.
    function automatic logic [3:0] last_idx(input int width);
        return 4'(width - 1);
    endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// rtl/mdio_edge_sync.sv - MDC/MDIO synchronizers and MDC rising-edge detector
//
// Purpose: brings the asynchronous MDC/MDIO pins into the clk domain.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   mdc         raw MDC pin
//   mdio        raw MDIO pin
//   mdc_rise    one-clk pulse on a synchronized MDC rising edge
//   mdio_s      synchronized MDIO level

module mdio_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdio,
    output logic mdc_rise,
    output logic mdio_s
);

    logic [1:0] mdc_sync;
    logic       mdc_d;
    logic [1:0] mdio_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_sync  <= 2'b00;
            mdc_d     <= 1'b0;
            // MDIO idles high through its pull-up.
            mdio_sync <= 2'b11;
        end else begin
            mdc_sync  <= {mdc_sync[0], mdc};
            mdc_d     <= mdc_sync[1];
            mdio_sync <= {mdio_sync[0], mdio};
        end
    end

    assign mdc_rise = mdc_sync[1] & ~mdc_d;
    assign mdio_s   = mdio_sync[1];

endmodule

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause-22 MDIO target presenting a virtual PHY register file
//
// Purpose: decodes MDIO frames from an external master, issues register read
//          requests / write strobes and drives turnaround and read data.
// Optional feature macro: MDIO_PRE_SUPPRESS_EN (preamble suppression after
//          a completed frame).
// Ports:
//   clk, rst_n   system clock (>= 8x MDC), asynchronous active-low reset
//   mdc_i        MDC from the master
//   mdio_i       MDIO level on the wire
//   mdio_o       MDIO value driven by this block
//   mdio_oe      1 = this block drives MDIO
//   reg_addr     REGAD of the current frame
//   rd_req       one-cycle read request for reg_addr
//   rd_data      read data, stable from rd_req+1 until the TA1 rise
//   wr_en        one-cycle write strobe for wr_data to reg_addr
//   wr_data      write data, held until the next write
//   busy         frame in progress
//   frame_err    one-cycle pulse on a malformed or timed-out frame

module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'd0,
    parameter int                 PREAMBLE_MIN = 32,
    parameter int                 IDLE_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mdc_i,
    input  logic                mdio_i,
    output logic                mdio_o,
    output logic                mdio_oe,
    output logic [REGAD_W-1:0]  reg_addr,
    output logic                rd_req,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                wr_en,
    output logic [DATA_W-1:0]   wr_data,
    output logic                busy,
    output logic                frame_err
);

    localparam int PW = $clog2(PREAMBLE_MIN + 1);
    localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [PW-1:0] PRE_FULL   = PW'(PREAMBLE_MIN);
    localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);

`ifdef MDIO_PRE_SUPPRESS_EN
    localparam bit PRE_SUPPRESS = 1'b1;
`else
    localparam bit PRE_SUPPRESS = 1'b0;
`endif

    logic mdc_rise;
    logic mdio_s;

    mdio_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc      (mdc_i),
        .mdio     (mdio_i),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_s)
    );

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic [PW-1:0]       pre_cnt, pre_n;
    logic                pre_sup, pre_sup_n;
    logic                is_read, is_read_n;
    logic                drop, drop_n;
    logic [DATA_W-1:0]   sh, sh_n;
    logic [TW-1:0]       timer, timer_n;
    logic                mdio_o_n, mdio_oe_n;
    logic [REGAD_W-1:0]  reg_addr_n;
    logic                rd_req_n, wr_en_n, frame_err_n, busy_n;
    logic [DATA_W-1:0]   wr_data_n;

    // Address fields complete with the bit being sampled this cycle.
    logic [4:0] field5;
    logic [1:0] op_code;
    assign field5  = {sh[3:0], mdio_s};
    assign op_code = {sh[0], mdio_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pre_cnt   <= '0;
            pre_sup   <= 1'b0;
            is_read   <= 1'b0;
            drop      <= 1'b0;
            sh        <= '0;
            timer     <= '0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
            reg_addr  <= '0;
            rd_req    <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pre_cnt   <= pre_n;
            pre_sup   <= pre_sup_n;
            is_read   <= is_read_n;
            drop      <= drop_n;
            sh        <= sh_n;
            timer     <= timer_n;
            mdio_o    <= mdio_o_n;
            mdio_oe   <= mdio_oe_n;
            reg_addr  <= reg_addr_n;
            rd_req    <= rd_req_n;
            wr_en     <= wr_en_n;
            wr_data   <= wr_data_n;
            busy      <= busy_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        pre_n       = pre_cnt;
        pre_sup_n   = pre_sup;
        is_read_n   = is_read;
        drop_n      = drop;
        sh_n        = sh;
        mdio_o_n    = mdio_o;
        mdio_oe_n   = mdio_oe;
        reg_addr_n  = reg_addr;
        wr_data_n   = wr_data;
        busy_n      = busy;
        rd_req_n    = 1'b0;
        wr_en_n     = 1'b0;
        frame_err_n = 1'b0;

        // Watchdog runs only while a frame is open; every MDC rise rearms it.
        if (mdc_rise || !busy) begin
            timer_n = '0;
        end else begin
            timer_n = timer + 1'b1;
        end

        if (busy && !mdc_rise && (timer == TIMER_LAST)) begin
            state_n     = IDLE;
            busy_n      = 1'b0;
            mdio_oe_n   = 1'b0;
            mdio_o_n    = 1'b1;
            frame_err_n = 1'b1;
            pre_n       = '0;
            pre_sup_n   = 1'b0;
        end else if (mdc_rise) begin
            case (state)
                IDLE: begin
                    if (mdio_s) begin
                        if (pre_cnt != PRE_FULL) begin
                            pre_n = pre_cnt + 1'b1;
                        end
                        // After a clean frame one idle 1 stands in for the preamble.
                        if (PRE_SUPPRESS && pre_sup) begin
                            pre_n = PRE_FULL;
                        end
                    end else if (pre_cnt == PRE_FULL) begin
                        state_n = ST;
                        pre_n   = '0;
                    end else begin
                        pre_n = '0;
                    end
                end

                ST: begin
                    if (mdio_s == ST_CODE[0]) begin
                        state_n = OP;
                        busy_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        state_n     = IDLE;
                        frame_err_n = 1'b1;
                        pre_sup_n   = 1'b0;
                    end
                end

                OP: begin
                    sh_n = {sh[DATA_W-2:0], mdio_s};
                    if (cnt == last_idx(OP_W)) begin
                        cnt_n = '0;
                        if (op_code == OP_READ) begin
                            is_read_n = 1'b1;
                            state_n   = PHYAD;
                        end else if (op_code == OP_WRITE) begin
                            is_read_n = 1'b0;
                            state_n   = PHYAD;
                        end else begin
                            state_n     = IDLE;
                            busy_n      = 1'b0;
                            frame_err_n = 1'b1;
                            pre_sup_n   = 1'b0;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end

                PHYAD: begin
                    sh_n = {sh[DATA_W-2:0], mdio_s};
                    if (cnt == last_idx(PHYAD_W)) begin
                        // Foreign PHY: keep tracking so we stay in frame sync.
                        drop_n  = (field5 != PHY_ADDR);
                        cnt_n   = '0;
                        state_n = REGAD;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end

                REGAD: begin
                    sh_n = {sh[DATA_W-2:0], mdio_s};
                    if (cnt == last_idx(REGAD_W)) begin
                        reg_addr_n = field5;
                        rd_req_n   = is_read && !drop;
                        cnt_n      = '0;
                        state_n    = TA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end

                TA: begin
                    if (cnt != last_idx(TA_W)) begin
                        // TA1: capture read data and pull the line low for TA2.
                        if (is_read && !drop) begin
                            sh_n      = rd_data;
                            mdio_oe_n = 1'b1;
                            mdio_o_n  = 1'b0;
                        end
                        cnt_n = cnt + 1'b1;
                    end else begin
                        if (is_read && !drop) begin
                            mdio_o_n = sh[DATA_W-1];
                            sh_n     = {sh[DATA_W-2:0], 1'b0};
                        end
                        cnt_n   = '0;
                        state_n = DATA;
                    end
                end

                DATA: begin
                    if (is_read) begin
                        if (!drop && (cnt != last_idx(DATA_W))) begin
                            mdio_o_n = sh[DATA_W-1];
                            sh_n     = {sh[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        sh_n = {sh[DATA_W-2:0], mdio_s};
                    end

                    if (cnt == last_idx(DATA_W)) begin
                        if (!is_read && !drop) begin
                            wr_data_n = {sh[DATA_W-2:0], mdio_s};
                            wr_en_n   = 1'b1;
                        end
                        mdio_oe_n = 1'b0;
                        mdio_o_n  = 1'b1;
                        state_n   = IDLE;
                        busy_n    = 1'b0;
                        pre_n     = '0;
                        pre_sup_n = 1'b1;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end

                default: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- Clause-22 MDIO target (PHY-side responder) that lets the FPGA present a virtual PHY register file to an external MDIO master.
- Oversamples MDC/MDIO in the system clock and decodes preamble, ST, OP, PHYAD, REGAD, TA and DATA.
- Issues register read requests and write strobes to local register logic, and drives turnaround and read data back onto MDIO.
- Complements the team's polling MDIO initiator; used for PHY emulation and for the initiator's loopback bench.

Parameters:
- PHY_ADDR, 5'd0: PHYAD this block answers to.
- PREAMBLE_MIN, 32: consecutive sampled 1s required before ST is accepted.
- IDLE_TIMEOUT, 4096: clk cycles with no MDC rise mid-frame before the frame is aborted.

Ports:
- clk  in  1  system clock; must be ≥8× MDC frequency.
- rst_n  in  1  asynchronous, active-low reset.
- mdc_i  in  1  MDC from the master; asynchronous to clk.
- mdio_i  in  1  MDIO value driven by the master; asynchronous to clk.
- mdio_o  out  1  MDIO value this block drives.
- mdio_oe  out  1  MDIO output enable; 1 = this block drives the line.
- reg_addr  out  5  REGAD of the current frame.
- rd_req  out  1  one-cycle pulse: read of reg_addr requested.
- rd_data  in  16  read data; must be stable from rd_req+1 until the TA1 rise.
- wr_en  out  1  one-cycle pulse: write wr_data to reg_addr.
- wr_data  out  16  write data; valid with wr_en and held until the next frame.
- busy  out  1  frame in progress, from ST through the end of DATA.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset values: mdio_o=1, mdio_oe=0, reg_addr=0, rd_req=0, wr_en=0, wr_data=0, busy=0, frame_err=0; state IDLE; preamble count 0.
- A reset asserted mid-frame releases MDIO immediately (asynchronously).
- Input sampling:
  - mdc_i and mdio_i each pass through a 2-flop synchronizer.
  - rise = synced MDC AND NOT delayed synced MDC.
  - All bit sampling happens on a rise cycle, using synced MDIO.
  - Output changes take effect on the clk edge after the rise cycle. Latency from MDC rise to mdio_o change is 3 clk cycles.
- IDLE:
  - A sampled 1 increments the preamble count, saturating at PREAMBLE_MIN.
  - A sampled 0 with count==PREAMBLE_MIN is ST bit 0 → ST. A sampled 0 otherwise clears the count.
- ST: sampled 1 → OP and busy=1. Sampled 0 → frame_err pulse, then IDLE.
- OP: 2 bits, MSB first.
  - 10 = read, 01 = write.
  - 00 or 11 → frame_err, then IDLE.
- PHYAD: 5 bits. A mismatch with PHY_ADDR sets a drop flag: the frame is still tracked to its end, but no strobes fire and mdio_oe is never raised.
- REGAD: 5 bits.
  - reg_addr updates on the last bit.
  - For a read with matching PHYAD, rd_req pulses on that same update cycle.
- TA, read: rd_data is latched into the shift register on the TA1 rise. mdio_oe=1 and mdio_o=0 from that point, so the block drives 0 at TA2.
- TA, write: the 2 bits are sampled but not checked.
- DATA: 16 bits, MSB first.
  - Read: after each rise the next bit is presented. Bit15 appears after the TA2 rise; bit0 appears after the D1 rise. mdio_oe=0 and mdio_o=1 after the D0 rise.
  - Write: bits shift in. After D0, wr_data updates and wr_en pulses on the same cycle.
- End of frame: → IDLE, busy=0, preamble count cleared.
- Timeout: with busy=1 and no rise for IDLE_TIMEOUT clk cycles → mdio_oe=0, frame_err pulse, then IDLE.
- Simultaneous events: reset dominates everything; timeout and rise cannot coincide, because a rise clears the timer.

Optional Feature:
- Macro: MDIO_PRE_SUPPRESS_EN.
- Defined: preamble suppression is supported. After the first frame completes, a single sampled 1 in IDLE satisfies the preamble requirement; PREAMBLE_MIN applies only after reset or after a frame_err.
- Undefined: every frame needs PREAMBLE_MIN ones.

Decomposition:
- Package mdio_pkg:
  - ST code 2'b01.
  - OP_READ 2'b10, OP_WRITE 2'b01.
  - Frame field widths.
  - State enum: IDLE, ST, OP, PHYAD, REGAD, TA, DATA.
- Sub-module mdio_edge_sync: 2-flop synchronizers for MDC and MDIO, plus the rise detector. Outputs: mdc_rise, mdio_s.

Test Plan:
- Read: 32×1, then 01 10 00000 00010 at clk=125MHz, MDC=2.5MHz, rd_data=16'h0141 → rd_req one pulse with reg_addr=2; MDIO carries Z,0 at TA then 0000000101000001; mdio_oe drops after D0.
- Write: 32×1, 01 01 00000 00000 10 16'h8000 → one wr_en pulse, wr_data=16'h8000, reg_addr=0; mdio_oe stays 0 throughout.
- PHYAD=00011 read with PHY_ADDR=0 → no rd_req, mdio_oe stays 0; a following valid frame is accepted.
- Short preamble of 20 ones, then a valid frame → ignored with no strobes; OP=11 after a full preamble → frame_err pulse, no strobes.
- MDC stops after TA1 of a read → mdio_oe=0 and a frame_err pulse after 4096 cycles. rst_n low mid-DATA → mdio_oe=0 immediately.
- MDIO_PRE_SUPPRESS_EN defined: two back-to-back reads separated by a single idle 1 → both answered. Undefined → the second is ignored.
